prog_loader: RTL and testbench

//   Writer side of the instruction/data RAM that the cpu core reads.

---
 rtl/prog_loader.sv | 194 +++++++++++++++++++
 tb/tb_prog_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: writer side of the cpu instruction/data RAM.
//   Accepts a byte stream framed as LEN_HI, LEN_LO (big-endian 16b word count N),
//   4*N payload bytes (each word MSB first) and one XOR checksum byte over the payload.
//   Words are written to RAM from BASE_ADDR upward; cpu_hold stays high until the
//   image is loaded and its checksum matches.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 1-cycle pulse that begins a new load (IDLE/DONE/ERR only)
//   in_data/in_valid      stream byte and its valid
//   in_ready              byte accepted when in_valid & in_ready
//   mem_we/addr/wdata     RAM write port, one strobe per assembled word
//   cpu_hold              1 = cpu must not fetch/execute
//   done / err            level flags for a good / failed load
//   words_loaded          words written in the current or last load
module prog_loader #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned DEPTH     = 4096,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned LEN_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [23:0]        word_q, word_d;      // first three bytes of the word being assembled
    logic [1:0]         idx_q, idx_d;
    logic [7:0]         acc_q, acc_d;
    logic               in_ready_q, in_ready_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic               cpu_hold_q, cpu_hold_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   words_q, words_d;

    logic               xfer_c;
    logic [LEN_W-1:0]   len_full_c;

    assign xfer_c     = in_valid & in_ready_q;
    assign len_full_c = {len_q[15:8], in_data};

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            word_q      <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            words_q     <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_q      <= word_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            err_q       <= err_d;
            words_q     <= words_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_d      = word_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        done_d      = done_q;
        err_d       = err_q;
        words_d     = words_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_LEN_HI;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    words_d    = '0;
                    acc_d      = '0;
                    idx_d      = '0;
                    cpu_hold_d = 1'b1;
                end
            end
            S_LEN_HI: begin
                if (xfer_c) begin
                    len_d   = {in_data, len_q[7:0]};
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer_c) begin
                    len_d = len_full_c;
                    if (32'(len_full_c) > DEPTH) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else if (len_full_c == '0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer_c) begin
                    word_d = {word_q[15:0], in_data};
                    acc_d  = acc_q ^ in_data;
                    idx_d  = idx_q + 2'd1;
                    // Fourth byte completes a word: write it on the next cycle
                    if (idx_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = {word_q, in_data};
                        mem_addr_d  = ADDR_W'(BASE_ADDR) + words_q[ADDR_W-1:0];
                        words_d     = words_q + CNT_W'(1);
                        if (17'(words_q) + 17'd1 == {1'b0, len_q}) begin
                            state_d = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (xfer_c) begin
                    if (in_data == acc_q) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                     (state_d == S_DATA)   || (state_d == S_CSUM);
    end

    assign in_ready     = in_ready_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign cpu_hold     = cpu_hold_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed self-checking bench for prog_loader.
module tb_prog_loader;

    localparam int unsigned ADDR_W = 12;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    int checks = 0;
    int errors = 0;

    // Write log filled by the monitor only
    logic [ADDR_W-1:0] wr_addr [16];
    logic [31:0]       wr_data [16];
    int                wr_cnt = 0;

    // Frame buffer used by send_frame
    logic [7:0] frm [16];
    int         frm_len;

    prog_loader #(.ADDR_W(ADDR_W), .DEPTH(4096), .BASE_ADDR(0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            if (wr_cnt < 16) begin
                wr_addr[wr_cnt] = mem_addr;
                wr_data[wr_cnt] = mem_wdata;
            end
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Present one byte from a negedge and hold it until it is taken at a posedge
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Send frm[0..frm_len-1]; optional random gaps; optional start pulse before byte start_at
    task automatic send_frame(input int max_gap, input int start_at);
        for (int i = 0; i < frm_len; i++) begin
            if (i == start_at) pulse_start();
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
            send_byte(frm[i]);
        end
        @(negedge clk);
    endtask

    task automatic load_good_frame();
        logic [7:0] f [11];
        f = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h05, 8'h00, 8'h22, 8'h18, 8'h20, 8'h22};
        for (int i = 0; i < 11; i++) frm[i] = f[i];
        frm_len = 11;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        #12;
        checks++;
        if ({in_ready, mem_we, cpu_hold, done, err} !== 5'b00100) begin
            errors++;
            $display("FAIL reset_flags: got %b required 00100", {in_ready, mem_we, cpu_hold, done, err});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0 || words_loaded !== '0) begin
            errors++;
            $display("FAIL reset_values: addr=%h wdata=%h words=%0d required 0", mem_addr, mem_wdata, words_loaded);
        end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: in_ready=%b required 0", in_ready);
        end
    endtask

    task automatic test_good_frame(input int max_gap, input int start_at, input string tag);
        int base;
        base = wr_cnt;
        load_good_frame();
        pulse_start();
        checks++;
        if (in_ready !== 1'b1 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL %s_armed: in_ready=%b cpu_hold=%b required 1 1", tag, in_ready, cpu_hold);
        end
        send_frame(max_gap, start_at);
        checks++;
        if (wr_cnt - base !== 2) begin
            errors++;
            $display("FAIL %s_wr_count: got %0d required 2", tag, wr_cnt - base);
        end else begin
            checks++;
            if (wr_addr[base] !== 12'd0 || wr_data[base] !== 32'h3C010005) begin
                errors++;
                $display("FAIL %s_word0: addr=%h data=%h required 000 3c010005", tag, wr_addr[base], wr_data[base]);
            end
            checks++;
            if (wr_addr[base+1] !== 12'd1 || wr_data[base+1] !== 32'h00221820) begin
                errors++;
                $display("FAIL %s_word1: addr=%h data=%h required 001 00221820", tag, wr_addr[base+1], wr_data[base+1]);
            end
        end
        checks++;
        if ({done, err, cpu_hold, in_ready} !== 4'b1000 || words_loaded !== 13'd2) begin
            errors++;
            $display("FAIL %s_result: done/err/hold/rdy=%b words=%0d required 1000 2", tag,
                     {done, err, cpu_hold, in_ready}, words_loaded);
        end
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 12'd1 || mem_wdata !== 32'h00221820) begin
            errors++;
            $display("FAIL %s_hold_bus: we=%b addr=%h data=%h required 0 001 00221820", tag, mem_we, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_bad_csum();
        int base;
        base = wr_cnt;
        load_good_frame();
        frm[10] = 8'h23;
        pulse_start();
        checks++;
        if (done !== 1'b0 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL restart_clears: done=%b hold=%b required 0 1", done, cpu_hold);
        end
        send_frame(0, -1);
        checks++;
        if (wr_cnt - base !== 2) begin
            errors++;
            $display("FAIL badcsum_wr_count: got %0d required 2", wr_cnt - base);
        end
        checks++;
        if ({done, err, cpu_hold} !== 3'b011 || words_loaded !== 13'd2) begin
            errors++;
            $display("FAIL badcsum_result: done/err/hold=%b words=%0d required 011 2", {done, err, cpu_hold}, words_loaded);
        end
    endtask

    task automatic test_len_err();
        int base;
        base = wr_cnt;
        frm[0] = 8'h10; frm[1] = 8'h01; frm_len = 2;
        pulse_start();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL lenerr_start_clear: err=%b required 0", err);
        end
        send_frame(0, -1);
        checks++;
        if ({done, err, cpu_hold, in_ready} !== 4'b0110) begin
            errors++;
            $display("FAIL lenerr_result: done/err/hold/rdy=%b required 0110", {done, err, cpu_hold, in_ready});
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wr_cnt - base !== 0 || words_loaded !== '0) begin
            errors++;
            $display("FAIL lenerr_no_writes: writes=%0d words=%0d required 0 0", wr_cnt - base, words_loaded);
        end
    endtask

    task automatic test_reset_mid();
        load_good_frame();
        frm_len = 7;
        pulse_start();
        send_frame(0, -1);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, mem_we, cpu_hold, done, err} !== 5'b00100) begin
            errors++;
            $display("FAIL midreset_flags: got %b required 00100", {in_ready, mem_we, cpu_hold, done, err});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0 || words_loaded !== '0) begin
            errors++;
            $display("FAIL midreset_values: addr=%h wdata=%h words=%0d required 0", mem_addr, mem_wdata, words_loaded);
        end
        @(negedge clk) rst_n = 1'b1;
        test_good_frame(0, -1, "after_reset");
    endtask

    task automatic test_zero_len();
        int base;
        base = wr_cnt;
        frm[0] = 8'h00; frm[1] = 8'h00; frm[2] = 8'h00; frm_len = 3;
        pulse_start();
        send_frame(0, -1);
        checks++;
        if ({done, err, cpu_hold} !== 3'b100 || words_loaded !== '0 || wr_cnt - base !== 0) begin
            errors++;
            $display("FAIL zerolen_result: done/err/hold=%b words=%0d writes=%0d required 100 0 0",
                     {done, err, cpu_hold}, words_loaded, wr_cnt - base);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame(0, -1, "basic");
        test_bad_csum();
        test_len_err();
        test_good_frame(5, -1, "gaps");
        test_reset_mid();
        test_zero_len();
        test_good_frame(0, 5, "start_mid_data");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
